// File: rtl/aline_pkt_pkg.sv
// Shared types and constants for the A-line packet writer.
// Also holds the data-word offset helper used when addressing a bank.
package aline_pkt_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_BANK,
    ST_ARM,
    ST_CAPTURE,
    ST_HEADER,
    ST_DONE
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int         BANK_W    = 13;

  // Offset 0 of every bank holds the header, so data words start at 1.
  function automatic logic [BANK_W-1:0] word_offset(
    input logic [BANK_W-1:0] aline,
    input logic [BANK_W-1:0] half_samples,
    input logic [BANK_W-1:0] word_idx
  );
    return 13'd1 + aline * half_samples + word_idx;
  endfunction

endpackage

// File: rtl/aline_bank_arbiter.sv
// Ping-pong bank ownership: a bank is busy from packet completion until the host releases it.
// A release aimed at the bank currently being filled is ignored.
module aline_bank_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set_busy,
  input  logic       i_set_sel,
  input  logic       i_release,
  input  logic       i_release_sel,
  input  logic       i_cur_bank,
  input  logic       i_writing,
  output logic [1:0] o_bank_free
);

  logic [1:0] r_busy;
  logic       w_rel_ok;
  logic [1:0] w_rel_mask;
  logic [1:0] w_set_mask;

  assign w_rel_ok   = i_release && !(i_writing && (i_release_sel == i_cur_bank));
  assign w_rel_mask = w_rel_ok   ? (2'b01 << i_release_sel) : 2'b00;
  assign w_set_mask = i_set_busy ? (2'b01 << i_set_sel)     : 2'b00;

  // A same-cycle release already counts as free for the caller's decision.
  assign o_bank_free = ~r_busy | w_rel_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 2'b00;
    end else begin
      r_busy <= (r_busy & ~w_rel_mask) | w_set_mask;
    end
  end

endmodule

// File: rtl/aline_packet_writer.sv
// Packs 16-bit ADC samples two per word into one bank of the packet memory,
// appends a header word, then hands the bank to the host and ping-pongs.
//   state        | meaning
//   ST_WAIT_BANK | current bank still owned by host
//   ST_ARM       | waiting for sweep_trig
//   ST_CAPTURE   | taking SAMPLES samples of one A-line
//   ST_HEADER    | writing header word at offset 0
//   ST_DONE      | pulsing packet_ready, switching bank
module aline_packet_writer
  import aline_pkt_pkg::*;
#(
  parameter int SAMPLES = 1024,
  parameter int ALINES  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sweep_trig,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        bank_release,
  input  logic        bank_release_sel,
  output logic [13:0] address2,
  output logic [31:0] writedata2,
  output logic [3:0]  byteenable2,
  output logic        chipselect2,
  output logic        write2,
  output logic        clken2,
  output logic        packet_ready,
  output logic        packet_bank,
  output logic        overflow,
  output logic [15:0] dropped_alines
);

  localparam int IDX_W = $clog2(SAMPLES);
  localparam int ALN_W = $clog2(ALINES + 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_cur_bank;
  logic [IDX_W-1:0] r_sample_idx;
  logic [ALN_W-1:0] r_aline_cnt;
  logic [15:0]      r_lo;
  logic [15:0]      r_pkt_seq;
  logic [1:0]       w_bank_free;
  logic             w_last;
  logic             w_wr;
  logic [13:0]      w_addr;
  logic [31:0]      w_data;
  logic             w_ready;

  aline_bank_arbiter u_arb (
    .clk           (clk),
    .reset         (reset),
    .i_set_busy    (r_state == ST_DONE),
    .i_set_sel     (r_cur_bank),
    .i_release     (bank_release),
    .i_release_sel (bank_release_sel),
    .i_cur_bank    (r_cur_bank),
    .i_writing     (r_state != ST_WAIT_BANK),
    .o_bank_free   (w_bank_free)
  );

  assign w_last = sample_valid && (r_sample_idx == IDX_W'(SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ARM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT_BANK: if (w_bank_free[r_cur_bank]) w_next = ST_ARM;
      ST_ARM:       if (sweep_trig) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (w_last) begin
          w_next = (r_aline_cnt == ALN_W'(ALINES - 1)) ? ST_HEADER : ST_ARM;
        end
      end
      ST_HEADER:    w_next = ST_DONE;
      ST_DONE:      w_next = w_bank_free[~r_cur_bank] ? ST_ARM : ST_WAIT_BANK;
      default:      w_next = ST_ARM;
    endcase
  end

  always_comb begin
    w_wr    = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_ready = 1'b0;
    case (r_state)
      ST_CAPTURE: begin
        if (sample_valid && r_sample_idx[0]) begin
          w_wr   = 1'b1;
          w_addr = {r_cur_bank, word_offset(BANK_W'(r_aline_cnt), BANK_W'(SAMPLES / 2),
                                            BANK_W'(r_sample_idx >> 1))};
          w_data = {sample_data, r_lo};
        end
      end
      ST_HEADER: begin
        w_wr   = 1'b1;
        w_addr = {r_cur_bank, {BANK_W{1'b0}}};
        w_data = {HDR_MAGIC, 8'(ALINES), r_pkt_seq};
      end
      ST_DONE: w_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write2         <= 1'b0;
      address2       <= '0;
      writedata2     <= '0;
      packet_ready   <= 1'b0;
      packet_bank    <= 1'b0;
      overflow       <= 1'b0;
      dropped_alines <= '0;
      r_cur_bank     <= 1'b0;
      r_sample_idx   <= '0;
      r_aline_cnt    <= '0;
      r_lo           <= '0;
      r_pkt_seq      <= '0;
    end else begin
      write2       <= w_wr;
      packet_ready <= w_ready;
      if (w_wr) begin
        address2   <= w_addr;
        writedata2 <= w_data;
      end
      if (r_state == ST_CAPTURE && sample_valid) begin
        if (!r_sample_idx[0]) r_lo <= sample_data;
        if (w_last) begin
          r_sample_idx <= '0;
          r_aline_cnt  <= (r_aline_cnt == ALN_W'(ALINES - 1)) ? '0 : r_aline_cnt + 1'b1;
        end else begin
          r_sample_idx <= r_sample_idx + 1'b1;
        end
      end
      if (r_state == ST_HEADER) r_pkt_seq <= r_pkt_seq + 16'd1;
      if (r_state == ST_DONE) begin
        r_cur_bank  <= ~r_cur_bank;
        packet_bank <= r_cur_bank;
      end
      // A trigger while waiting for a bank loses that whole A-line.
      if (r_state == ST_WAIT_BANK && sweep_trig) begin
        overflow <= 1'b1;
        if (dropped_alines != 16'hFFFF) dropped_alines <= dropped_alines + 16'd1;
      end
    end
  end

  assign chipselect2 = write2;
  assign byteenable2 = 4'hF;
  assign clken2      = 1'b1;

endmodule

// File: tb/tb_aline_packet_writer.sv
// Scoreboard bench for aline_packet_writer with SAMPLES=4, ALINES=2.
// Stimulus pushes hand-computed writes/ready pulses; a negedge monitor checks them.
module tb_aline_packet_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sweep_trig = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        bank_release = 1'b0;
  logic        bank_release_sel = 1'b0;
  logic [13:0] address2;
  logic [31:0] writedata2;
  logic [3:0]  byteenable2;
  logic        chipselect2;
  logic        write2;
  logic        clken2;
  logic        packet_ready;
  logic        packet_bank;
  logic        overflow;
  logic [15:0] dropped_alines;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_rdy[$];
  wr_t  e_wr;
  logic e_rdy;
  int   errors = 0;
  int   checks = 0;

  aline_packet_writer #(.SAMPLES(4), .ALINES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .sweep_trig       (sweep_trig),
    .sample_valid     (sample_valid),
    .sample_data      (sample_data),
    .bank_release     (bank_release),
    .bank_release_sel (bank_release_sel),
    .address2         (address2),
    .writedata2       (writedata2),
    .byteenable2      (byteenable2),
    .chipselect2      (chipselect2),
    .write2           (write2),
    .clken2           (clken2),
    .packet_ready     (packet_ready),
    .packet_bank      (packet_bank),
    .overflow         (overflow),
    .dropped_alines   (dropped_alines)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (write2) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h", address2, writedata2);
        end else begin
          e_wr = exp_wr.pop_front();
          if (address2 !== e_wr.a || writedata2 !== e_wr.d || chipselect2 !== 1'b1
              || byteenable2 !== 4'hF || clken2 !== 1'b1) begin
            errors++;
            $display("FAIL write addr=%h data=%h cs=%b be=%h expected addr=%h data=%h",
                     address2, writedata2, chipselect2, byteenable2, e_wr.a, e_wr.d);
          end
        end
      end
      if (packet_ready) begin
        checks++;
        if (exp_rdy.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready bank=%b", packet_bank);
        end else begin
          e_rdy = exp_rdy.pop_front();
          if (packet_bank !== e_rdy) begin
            errors++;
            $display("FAIL ready_bank actual=%b expected=%b", packet_bank, e_rdy);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  // With gap set, each sample is followed by an idle cycle and a stray trigger is
  // raised in the idle cycle after the second sample.
  task automatic send_aline(input logic [15:0] base, input bit gap);
    sweep_trig = 1'b1;
    tick();
    sweep_trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_data  = base + 16'(i);
      tick();
      sample_valid = 1'b0;
      if (gap) begin
        sweep_trig = (i == 1);
        tick();
        sweep_trig = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rdy.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    if (exp_wr.size() != 0 || exp_rdy.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending_writes=%0d pending_ready=%0d", name,
               exp_wr.size(), exp_rdy.size());
      exp_wr.delete();
      exp_rdy.delete();
    end
    tick();
    tick();
  endtask

  task automatic release_bank(input logic sel);
    bank_release     = 1'b1;
    bank_release_sel = sel;
    tick();
    bank_release = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_write2"},       32'(write2), 32'h0);
    chk({tag, "_chipselect2"},  32'(chipselect2), 32'h0);
    chk({tag, "_packet_ready"}, 32'(packet_ready), 32'h0);
    chk({tag, "_address2"},     32'(address2), 32'h0);
    chk({tag, "_writedata2"},   writedata2, 32'h0);
    chk({tag, "_overflow"},     32'(overflow), 32'h0);
    chk({tag, "_dropped"},      32'(dropped_alines), 32'h0);
    chk({tag, "_packet_bank"},  32'(packet_bank), 32'h0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("por");
    chk("byteenable2", 32'(byteenable2), 32'hF);
    chk("clken2", 32'(clken2), 32'h1);
    reset = 1'b0;
    tick();

    // Packet 1: bank 0, seq 0
    push_wr(14'h0001, 32'h00020001);
    push_wr(14'h0002, 32'h00040003);
    push_wr(14'h0003, 32'h00060005);
    push_wr(14'h0004, 32'h00080007);
    push_wr(14'h0000, 32'hA5020000);
    exp_rdy.push_back(1'b0);
    send_aline(16'h0001, 1'b0);
    send_aline(16'h0005, 1'b0);
    wait_drain("pkt1");

    // Packet 2: bank 1, seq 1
    push_wr(14'h2001, 32'h00120011);
    push_wr(14'h2002, 32'h00140013);
    push_wr(14'h2003, 32'h00160015);
    push_wr(14'h2004, 32'h00180017);
    push_wr(14'h2000, 32'hA5020001);
    exp_rdy.push_back(1'b1);
    send_aline(16'h0011, 1'b0);
    send_aline(16'h0015, 1'b0);
    wait_drain("pkt2");

    // Both banks busy: trigger is dropped, nothing written
    sweep_trig = 1'b1;
    tick();
    sweep_trig = 1'b0;
    tick();
    chk("drop_overflow", 32'(overflow), 32'h1);
    chk("drop_count", 32'(dropped_alines), 32'h1);
    repeat (5) tick();

    // Packet 3 after releasing bank 0, with idle cycles and a stray trigger
    release_bank(1'b0);
    push_wr(14'h0001, 32'h00220021);
    push_wr(14'h0002, 32'h00240023);
    push_wr(14'h0003, 32'h00260025);
    push_wr(14'h0004, 32'h00280027);
    push_wr(14'h0000, 32'hA5020002);
    exp_rdy.push_back(1'b0);
    send_aline(16'h0021, 1'b1);
    send_aline(16'h0025, 1'b1);
    wait_drain("pkt3");
    chk("capture_trig_not_dropped", 32'(dropped_alines), 32'h1);

    // Partial A-line into bank 1, then reset
    release_bank(1'b1);
    push_wr(14'h2001, 32'hBBBBAAAA);
    sweep_trig = 1'b1;
    tick();
    sweep_trig = 1'b0;
    sample_valid = 1'b1;
    sample_data = 16'hAAAA;
    tick();
    sample_data = 16'hBBBB;
    tick();
    sample_data = 16'hCCCC;
    tick();
    sample_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    chk("partial_word_seen", 32'(exp_wr.size()), 32'h0);
    reset = 1'b0;
    tick();
    tick();

    // Packet 4: bank 0, seq 0 again
    push_wr(14'h0001, 32'h00320031);
    push_wr(14'h0002, 32'h00340033);
    push_wr(14'h0003, 32'h00360035);
    push_wr(14'h0004, 32'h00380037);
    push_wr(14'h0000, 32'hA5020000);
    exp_rdy.push_back(1'b0);
    send_aline(16'h0031, 1'b0);
    send_aline(16'h0035, 1'b0);
    wait_drain("pkt4");

    // Packet 5: bank 1, seq 1
    push_wr(14'h2001, 32'h00420041);
    push_wr(14'h2002, 32'h00440043);
    push_wr(14'h2003, 32'h00460045);
    push_wr(14'h2004, 32'h00480047);
    push_wr(14'h2000, 32'hA5020001);
    exp_rdy.push_back(1'b1);
    send_aline(16'h0041, 1'b0);
    send_aline(16'h0045, 1'b0);
    wait_drain("pkt5");
    chk("pre_sat_count", 32'(dropped_alines), 32'h0);

    // Saturation: 0xFFFF drops, then more
    sweep_trig = 1'b1;
    repeat (65535) tick();
    sweep_trig = 1'b0;
    tick();
    chk("sat_reach", 32'(dropped_alines), 32'hFFFF);
    sweep_trig = 1'b1;
    repeat (5) tick();
    sweep_trig = 1'b0;
    tick();
    chk("sat_hold", 32'(dropped_alines), 32'hFFFF);
    chk("sat_overflow", 32'(overflow), 32'h1);

    chk("final_pending_writes", 32'(exp_wr.size()), 32'h0);
    chk("final_pending_ready", 32'(exp_rdy.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
